// File: rtl/rst_sequencer_if.sv
// rtl/rst_sequencer_if.sv - reset sequencer control/status bundle
interface rst_sequencer_if #(
    parameter int STAGES = 4
);
    logic              sw_rst_req;
    logic              sw_rst_ack;
    logic [STAGES-1:0] rst_out_n;
    logic              ready;

    modport master (
        input  sw_rst_req,
        output sw_rst_ack,
        output rst_out_n,
        output ready
    );

    modport slave (
        output sw_rst_req,
        input  sw_rst_ack,
        input  rst_out_n,
        input  ready
    );
endinterface

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - ordered, synchronously released resets; async assertion.
// Optional software reset path enabled by DARKC_RST_SEQ_SW_RST_EN.
module rst_sequencer #(
    parameter int STAGES     = 4,
    parameter int SYNC_DEPTH = 2,
    parameter int STRETCH    = 16,
    parameter int GAP        = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    rst_sequencer_if.master bus
);
    localparam int MAXC = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] STR_LOAD = CW'(STRETCH - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);

    typedef enum logic [1:0] {S_RESET, S_STRETCH, S_RELEASE, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [STAGES-1:0]   rst_q, rst_d;
    logic                ready_q, ready_d;
    logic [SYNC_DEPTH-1:0] sync_q;
    logic                sync_out;
    logic [STAGES:0]     shifted;

    assign sync_out = sync_q[SYNC_DEPTH-1];
    // Next release pattern: one more low-order bit set.
    assign shifted  = {rst_q, 1'b1};

`ifdef DARKC_RST_SEQ_SW_RST_EN
    // The software path waits one extra stretch cycle so release lands at s+1+STRETCH.
    localparam logic [CW-1:0] SW_LOAD = CW'(STRETCH);
    logic req_q;
    logic req_rise;
    logic swact_q, swact_d;
    logic ack_q, ack_d;

    assign req_rise       = bus.sw_rst_req & ~req_q;
    assign bus.sw_rst_ack = ack_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            swact_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            req_q   <= bus.sw_rst_req;
            swact_q <= swact_d;
            ack_q   <= ack_d;
        end
    end
`else
    assign bus.sw_rst_ack = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= S_RESET;
            cnt_q   <= '0;
            rst_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_DEPTH-2:0], 1'b1};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        ready_d = ready_q;
`ifdef DARKC_RST_SEQ_SW_RST_EN
        swact_d = swact_q;
        ack_d   = 1'b0;
`endif
        case (state_q)
            S_RESET: begin
                if (sync_out) begin
                    state_d = S_STRETCH;
                    cnt_d   = STR_LOAD;
                end
            end
            S_STRETCH, S_RELEASE: begin
                if (cnt_q == '0) begin
                    rst_d = shifted[STAGES-1:0];
                    if (&shifted[STAGES-1:0]) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
`ifdef DARKC_RST_SEQ_SW_RST_EN
                        ack_d   = swact_q;
                        swact_d = 1'b0;
`endif
                    end else begin
                        state_d = S_RELEASE;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RUN: begin
`ifdef DARKC_RST_SEQ_SW_RST_EN
                if (req_rise) begin
                    state_d = S_STRETCH;
                    cnt_d   = SW_LOAD;
                    rst_d   = '0;
                    ready_d = 1'b0;
                    swact_d = 1'b1;
                end
`endif
            end
            default: state_d = S_RESET;
        endcase
    end

    assign bus.rst_out_n = rst_q;
    assign bus.ready     = ready_q;
endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Reset sequencer that turns the raw board/PLL reset into ordered, clock-synchronous active-low resets for downstream logic built from synchronous-reset flops. Assertion is asynchronous and immediate; deassertion is synchronized, stretched, then released stage by stage with a fixed gap, so dependent subsystems leave reset in a defined order. It sits between the top-level reset pin and every synchronous-reset flop group in its clock domain.

## Interface
Parameters:
- STAGES, 4: number of sequenced reset outputs (>=1).
- SYNC_DEPTH, 2: synchronizer flop count on rst_n deassertion (>=2).
- STRETCH, 16: cycles all outputs stay low after synchronized deassertion (>=1).
- GAP, 8: cycles between consecutive stage releases (>=1).

Ports:
- clk  in  1  the single clock.
- rst_n  in  1  asynchronous, active-low reset; assertion takes effect without a clock edge.
- sw_rst_req  in  1  software reset request; the rising edge is sampled.
- sw_rst_ack  out  1  one-cycle pulse when a software reset completes.
- rst_out_n  out  STAGES  per-stage synchronous active-low resets; bit 0 is released first.
- ready  out  1  high when all stages are released.

## Operation
- Reset values while rst_n=0: rst_out_n=0 (all bits), ready=0, sw_rst_ack=0, synchronizer chain=0, state=RESET, request edge detector cleared.
- All flops use asynchronous clear on rst_n. Every output is a flop output; no output is combinational.
- FSM states:
  - RESET: exits to STRETCH when the synchronizer output becomes 1.
  - STRETCH: holds for STRETCH cycles, then releases rst_out_n[0] and moves to RELEASE.
  - RELEASE: releases the next stage every GAP cycles. It moves to RUN and sets ready together with the release of bit STAGES-1.
  - RUN: holds all outputs high.
- If STAGES=1, the STRETCH exit releases bit 0, sets ready, and goes straight to RUN.
- A released bit stays at 1 until the next reset. Bits never toggle individually otherwise.
- Counter width is $clog2(max(STRETCH,GAP)+1). The counter is loaded on state entry and decrements to 0. There is no wrap-around.
- rst_n asserted in any state (including mid-sequence or during a software reset) clears everything at once and returns the block to RESET.
- A glitch on rst_n shorter than one cycle still fully restarts the sequence.

## Timing
- Let edge k be the first clk rising edge that samples rst_n=1. The synchronizer output rises after edge k+SYNC_DEPTH-1, and STRETCH is entered at edge k+SYNC_DEPTH.
- rst_out_n[0] rises at edge k+SYNC_DEPTH+STRETCH.
- rst_out_n[i] rises at edge k+SYNC_DEPTH+STRETCH+i*GAP.
- ready rises on the same edge as rst_out_n[STAGES-1].
- Silicon may shift edge k by one cycle (metastability). Benches change rst_n away from clk edges.
- Software reset: let edge s be the edge that samples sw_rst_req=1 in RUN, with sw_rst_req=0 sampled one edge earlier.
  - rst_out_n=0 and ready=0 after edge s, and the FSM enters STRETCH.
  - Release then follows the normal schedule: bit 0 rises at edge s+1+STRETCH, and bit i at s+1+STRETCH+i*GAP.
  - sw_rst_ack is high for exactly the one cycle following the edge where ready rises.
- Request rules:
  - A rising edge of sw_rst_req outside RUN is ignored and is not queued.
  - A request held high does not retrigger; a new rising edge is required.

## Configuration
- DARKC_RST_SEQ_SW_RST_EN defined: software reset path present as described above.
- Not defined: sw_rst_req is ignored, sw_rst_ack is tied to 0, and the SWRST logic and edge detector are not instantiated. Power-on sequencing is unchanged, and the port list stays identical.

## Test plan
All tests use STAGES=3, SYNC_DEPTH=2, STRETCH=4, GAP=2.
- Power-on: deassert rst_n between edges, with edge k the first edge sampling 1 -> rst_out_n goes 000 to 001 at k+6, 011 at k+8, 111 at k+10; ready=1 at k+10; sw_rst_ack stays 0.
- Reset while running: after ready=1, pulse rst_n low for 0.3 cycle -> rst_out_n=000 and ready=0 immediately, with no clock edge needed; the full power-on sequence repeats from the new edge k.
- Reset mid-sequence: assert rst_n just after k+8, when rst_out_n=011 -> immediate 000; after re-release, bit 0 rises at k'+6 (no partial resume).
- Software reset (macro on): sw_rst_req 0 to 1 sampled at edge s in RUN -> 000 after s; 001 at s+5, 011 at s+7, 111 at s+9; sw_rst_ack high for exactly the cycle after s+9. Holding req high afterwards produces no second reset.
- Ignored request (macro on): raise sw_rst_req at k+7, during RELEASE, and hold it high -> sequence unchanged and no sw_rst_ack. Dropping and re-raising req in RUN then triggers a reset.
- Macro off: toggle sw_rst_req in RUN -> rst_out_n stays 111 and sw_rst_ack stays 0.
